// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised synchronous FIFO with any depth >= 2, programmable
// almost-full/almost-empty thresholds, occupancy count, synchronous flush and
// selectable standard or first-word-fall-through read mode.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (wins over flush)
//   flush       synchronous clear of contents; wr_en/rd_en ignored that cycle
//   data_in     write data
//   wr_en       write request
//   rd_en       read request
//   data_out    read data (registered in standard mode, head word in FWFT mode)
//   wr_ack      previous cycle's write was accepted
//   overflow    previous cycle's write was rejected
//   underflow   previous cycle's read was rejected
//   full, empty, almostfull, almostempty  status flags decoded from count
//   count       number of stored words
module fifo_sync_param #(
   parameter int FIFO_WIDTH      = 16,
   parameter int FIFO_DEPTH      = 8,
   parameter int ALMOST_FULL_TH  = 1,
   parameter int ALMOST_EMPTY_TH = 1,
   parameter int FWFT            = 0
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic [FIFO_WIDTH-1:0]              data_in,
   input  logic                               wr_en,
   input  logic                               rd_en,
   output logic [FIFO_WIDTH-1:0]              data_out,
   output logic                               wr_ack,
   output logic                               overflow,
   output logic                               underflow,
   output logic                               full,
   output logic                               empty,
   output logic                               almostfull,
   output logic                               almostempty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_wr_ack, r_overflow, r_underflow;
   logic                  w_rd_acc, w_wr_acc, w_run;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still accepts a write when a read frees the slot in the same cycle.
   assign w_rd_acc = rd_en && (r_count != '0);
   assign w_wr_acc = wr_en && ((r_count != CW'(FIFO_DEPTH)) || w_rd_acc);
   assign w_run    = !rst && !flush;

   always_ff @(posedge clk) begin
      if (w_run && w_wr_acc)
         r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!w_run) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_rd_acc)
            r_rd_ptr <= f_inc(r_rd_ptr);
         r_count     <= r_count + CW'(w_wr_acc && !w_rd_acc) - CW'(w_rd_acc && !w_wr_acc);
         r_wr_ack    <= w_wr_acc;
         r_overflow  <= wr_en && !w_wr_acc;
         r_underflow <= rd_en && !w_rd_acc;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : r_mem[r_rd_ptr];
      end else begin : g_std
         logic [FIFO_WIDTH-1:0] r_data_out;
         // On a full simultaneous read/write the old word is captured here before the slot is overwritten.
         always_ff @(posedge clk) begin
            if (rst)
               r_data_out <= '0;
            else if (!flush && w_rd_acc)
               r_data_out <= r_mem[r_rd_ptr];
         end
         assign data_out = r_data_out;
      end
   endgenerate

   assign count       = r_count;
   assign wr_ack      = r_wr_ack;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign full        = r_count == CW'(FIFO_DEPTH);
   assign empty       = r_count == '0;
   assign almostfull  = (r_count >= CW'(FIFO_DEPTH - ALMOST_FULL_TH)) && !full;
   assign almostempty = (r_count <= CW'(ALMOST_EMPTY_TH)) && !empty;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: self-checking bench driving three FIFO configurations from shared inputs.
module tb_fifo_sync_param;
   logic        clk = 1'b0;
   logic        rst = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [15:0] data_in = '0;

   logic [15:0] dout8, dout5, doutf;
   logic        ack8, ov8, un8, full8, empty8, af8, ae8;
   logic        ack5, ov5, un5, full5, empty5, af5, ae5;
   logic        ackf, ovf, unf, fullf, emptyf, aff, aef;
   logic [3:0]  cnt8;
   logic [2:0]  cnt5, cntf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .ALMOST_FULL_TH(1), .ALMOST_EMPTY_TH(1), .FWFT(0)) u8 (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .data_out(dout8), .wr_ack(ack8), .overflow(ov8), .underflow(un8), .full(full8), .empty(empty8),
      .almostfull(af8), .almostempty(ae8), .count(cnt8));

   fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .ALMOST_FULL_TH(1), .ALMOST_EMPTY_TH(1), .FWFT(0)) u5 (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .data_out(dout5), .wr_ack(ack5), .overflow(ov5), .underflow(un5), .full(full5), .empty(empty5),
      .almostfull(af5), .almostempty(ae5), .count(cnt5));

   fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(4), .ALMOST_FULL_TH(2), .ALMOST_EMPTY_TH(2), .FWFT(1)) uf (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .data_out(doutf), .wr_ack(ackf), .overflow(ovf), .underflow(unf), .full(fullf), .empty(emptyf),
      .almostfull(aff), .almostempty(aef), .count(cntf));

   // Reference model: each FIFO is a plain queue of words plus the last word read.
   logic [15:0] q8[$], q5[$], qf[$];
   logic [15:0] h8, h5, hf;
   bit          ma[3], mo[3], mu[3];

   typedef struct {
      bit          r, f, w, rd;
      logic [15:0] din;
      int          cnt;
      bit          ack, ov, un;
      logic [15:0] dout;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(bit r, bit f, bit w, bit rd, logic [15:0] din, int cnt,
                               bit ack, bit ov, bit un, logic [15:0] dout);
      vec_t v;
      v.r = r; v.f = f; v.w = w; v.rd = rd; v.din = din; v.cnt = cnt;
      v.ack = ack; v.ov = ov; v.un = un; v.dout = dout;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mstep(input int d, inout logic [15:0] q[$], inout logic [15:0] hd,
                        output bit ack, output bit ov, output bit un);
      bit ro, wo;
      if (rst || flush) begin
         q.delete();
         if (rst) hd = '0;
         ack = 0; ov = 0; un = 0;
      end else begin
         ro = rd_en && q.size() > 0;
         wo = wr_en && (q.size() < d || ro);
         if (ro) hd = q.pop_front();
         if (wo) q.push_back(data_in);
         ack = wo; ov = wr_en && !wo; un = rd_en && !ro;
      end
   endtask

   function automatic logic [63:0] mexp(int d, int aft, int aet, bit fw, logic [15:0] q[$],
                                        logic [15:0] hd, bit ack, bit ov, bit un);
      int n = q.size();
      logic [15:0] dv = fw ? ((n == 0) ? 16'h0 : q[0]) : hd;
      return {33'b0, dv, 8'(n), ack, ov, un, n == d, n == 0, (n >= d - aft) && (n != d), (n <= aet) && (n != 0)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      mstep(8, q8, h8, ma[0], mo[0], mu[0]);
      mstep(5, q5, h5, ma[1], mo[1], mu[1]);
      mstep(4, qf, hf, ma[2], mo[2], mu[2]);
      #1;
      chk("model d8", {33'b0, dout8, 8'(cnt8), ack8, ov8, un8, full8, empty8, af8, ae8},
          mexp(8, 1, 1, 0, q8, h8, ma[0], mo[0], mu[0]));
      chk("model d5", {33'b0, dout5, 8'(cnt5), ack5, ov5, un5, full5, empty5, af5, ae5},
          mexp(5, 1, 1, 0, q5, h5, ma[1], mo[1], mu[1]));
      chk("model fwft", {33'b0, doutf, 8'(cntf), ackf, ovf, unf, fullf, emptyf, aff, aef},
          mexp(4, 2, 2, 1, qf, hf, ma[2], mo[2], mu[2]));
   endtask

   task automatic drv(input bit r, input bit f, input bit w, input bit rd, input logic [15:0] din);
      rst = r; flush = f; wr_en = w; rd_en = rd; data_in = din;
   endtask

   initial begin
      bit r, f, w, rd;
      // Reset then fill, overflow, drain, underflow
      tv.push_back(mk(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0));
      tv.push_back(mk(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0));
      for (int k = 1; k <= 8; k++) tv.push_back(mk(0, 0, 1, 0, 16'(k), k, 1, 0, 0, 16'h0));
      tv.push_back(mk(0, 0, 1, 0, 16'hBEEF, 8, 0, 1, 0, 16'h0));
      for (int i = 1; i <= 8; i++) tv.push_back(mk(0, 0, 0, 1, 16'h0, 8 - i, 0, 0, 0, 16'(i)));
      tv.push_back(mk(0, 0, 0, 1, 16'h0, 0, 0, 0, 1, 16'h0008));
      // Simultaneous read/write when full, then when empty
      for (int k = 1; k <= 8; k++) tv.push_back(mk(0, 0, 1, 0, 16'(16'h10 + k), k, 1, 0, 0, 16'h0008));
      tv.push_back(mk(0, 0, 1, 1, 16'h00AA, 8, 1, 0, 0, 16'h0011));
      for (int i = 1; i <= 7; i++) tv.push_back(mk(0, 0, 0, 1, 16'h0, 8 - i, 0, 0, 0, 16'(16'h11 + i)));
      tv.push_back(mk(0, 0, 0, 1, 16'h0, 0, 0, 0, 0, 16'h00AA));
      tv.push_back(mk(0, 0, 1, 1, 16'h0055, 1, 1, 0, 1, 16'h00AA));
      // Flush at count 4 with a write pending, then rst+flush together
      for (int k = 1; k <= 3; k++) tv.push_back(mk(0, 0, 1, 0, 16'(16'h60 + k), 1 + k, 1, 0, 0, 16'h00AA));
      tv.push_back(mk(0, 1, 1, 0, 16'h0077, 0, 0, 0, 0, 16'h00AA));
      tv.push_back(mk(1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0));

      foreach (tv[i]) begin
         drv(tv[i].r, tv[i].f, tv[i].w, tv[i].rd, tv[i].din);
         cyc();
         chk($sformatf("vec%0d", i),
             {36'b0, dout8, cnt8, ack8, ov8, un8, full8, empty8, af8, ae8},
             {36'b0, tv[i].dout, 4'(tv[i].cnt), tv[i].ack, tv[i].ov, tv[i].un,
              tv[i].cnt == 8, tv[i].cnt == 0, tv[i].cnt == 7, tv[i].cnt == 1});
      end

      // Pointer wrap at depth 5: steady occupancy of 3 across many wraps
      drv(1, 0, 0, 0, 16'h0); cyc();
      for (int k = 1; k <= 3; k++) begin drv(0, 0, 1, 0, 16'(k)); cyc(); end
      for (int k = 1; k <= 23; k++) begin
         drv(0, 0, 1, 1, 16'(k + 3)); cyc();
         chk($sformatf("wrap5 dout %0d", k), 64'(dout5), 64'(k));
         chk($sformatf("wrap5 cnt %0d", k), 64'(cnt5), 64'd3);
      end

      // FWFT: word visible right after the write, gone after the pop
      drv(1, 0, 0, 0, 16'h0); cyc();
      chk("fwft reset dout", 64'(doutf), 64'd0);
      drv(0, 0, 1, 0, 16'h1234); cyc();
      chk("fwft head", {47'b0, doutf, emptyf}, {47'b0, 16'h1234, 1'b0});
      drv(0, 0, 0, 1, 16'h0); cyc();
      chk("fwft pop", {47'b0, doutf, emptyf}, {47'b0, 16'h0000, 1'b1});

      // Randomised traffic with phases biased towards filling and towards draining
      for (int i = 0; i < 800; i++) begin
         r  = $urandom_range(0, 99) == 0;
         f  = $urandom_range(0, 49) == 0;
         w  = $urandom_range(0, 3) < (((i / 50) % 2 == 0) ? 3 : 1);
         rd = $urandom_range(0, 3) < (((i / 50) % 2 == 0) ? 1 : 3);
         drv(r, f, w, rd, 16'($urandom));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO: next generation of the team's 16x8 FIFO.
- Adds the following over that design:
  - any depth ≥ 2, including non-power-of-two depths;
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count output;
  - a synchronous flush;
  - selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between the stimulus/producer side and any consumer. Status flags feed the scoreboard and coverage.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (≥1).
- FIFO_DEPTH, 8, number of storage entries (≥2, any integer).
- ALMOST_FULL_TH, 1, almostfull asserts when free entries ≤ this value (1..FIFO_DEPTH-1).
- ALMOST_EMPTY_TH, 1, almostempty asserts when stored entries ≤ this value (1..FIFO_DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents; lower priority than rst.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data.
- wr_ack  output  1  registered; previous cycle's write was accepted.
- overflow  output  1  registered; previous cycle's write was rejected.
- underflow  output  1  registered; previous cycle's read was rejected.
- full, empty, almostfull, almostempty  output  1 each  status flags derived from count.
- count  output  $clog2(FIFO_DEPTH+1)  number of stored words.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0.
  - data_out, wr_ack, overflow and underflow go to 0.
  - Flags go to: empty=1, full=0, almostfull=0, almostempty=0.
  - Memory contents are not cleared.
- Flush (flush=1, rst=0):
  - Same pointer, count, flag, wr_ack, overflow and underflow effect as reset.
  - data_out holds its value in standard mode.
  - wr_en and rd_en are ignored in that cycle; no write, no overflow or underflow reported.
- Read accept: rd_acc = rd_en & (count≠0).
- Write accept: wr_acc = wr_en & (count≠FIFO_DEPTH | rd_acc).
  - When full, a simultaneous accepted read frees a slot, so the write is accepted.
  - When empty, a simultaneous read is rejected; the write is still accepted.
- Count update each cycle:
  - +1 on wr_acc & !rd_acc;
  - −1 on rd_acc & !wr_acc;
  - unchanged when both or neither.
  - Never exceeds FIFO_DEPTH and never drops below 0.
- Pointers:
  - Range 0..FIFO_DEPTH-1.
  - Increment on their accept; wrap from FIFO_DEPTH-1 to 0 (no reliance on a power-of-two depth).
- Flags, combinational from count:
  - full = (count==FIFO_DEPTH).
  - empty = (count==0).
  - almostfull = (count ≥ FIFO_DEPTH-ALMOST_FULL_TH) & !full.
  - almostempty = (count ≤ ALMOST_EMPTY_TH) & !empty.
- Handshake outputs, registered one cycle after the request:
  - wr_ack = wr_acc.
  - overflow = wr_en & !wr_acc.
  - underflow = rd_en & !rd_acc.
  - wr_ack and overflow are mutually exclusive.
- Standard mode (FWFT=0):
  - On rd_acc, data_out loads mem[rd_ptr] at that edge, so data is visible one cycle after rd_en.
  - Otherwise data_out holds, including on an underflowed read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] while !empty, and 0 while empty.
  - A word written at edge N is visible on data_out after edge N when it becomes the head entry.
  - rd_en pops the head word; the next word (if any) appears after the same edge.
- Simultaneous read and write to the same entry (count 0 or FIFO_DEPTH):
  - count==0: the read is rejected, so no hazard.
  - count==FIFO_DEPTH: the read returns the old word, then the slot is overwritten.
- rst asserted mid-burst: the next cycle behaves exactly as after power-on reset. In-flight requests from that cycle are dropped and flag nothing.

Test Plan:
- Reset then fill (DEPTH=8, WIDTH=16, FWFT=0):
  - Stimulus: rst=1 for 2 cycles, then 8 writes 0x0001..0x0008.
  - Required: wr_ack=1 for 8 cycles, count 1..8; almostfull at count=7; full at count=8; almostempty at count=1.
- Overflow and underflow:
  - Stimulus: with the FIFO full, wr_en=1 with 0xBEEF; then drain 8 words and issue one more rd_en.
  - Required: overflow=1 one cycle later, count stays 8, 0xBEEF never appears on data_out; data_out returns 0x0001..0x0008 in order; the extra read gives underflow=1 with data_out holding 0x0008.
- Simultaneous read and write at the boundaries:
  - Stimulus: full FIFO with wr_en=rd_en=1 (data 0x00AA); then an empty FIFO with wr_en=rd_en=1 (data 0x0055).
  - Required: full case gives wr_ack=1, overflow=0, count=8, data_out=the oldest word. Empty case gives wr_ack=1, underflow=1, count=1.
- Pointer wrap at non-power-of-two depth (DEPTH=5):
  - Stimulus: 23 interleaved write/read pairs starting from count=3.
  - Required: data order is preserved across multiple wraps and count stays 3.
- FWFT mode (FWFT=1):
  - Stimulus: write 0x1234 into an empty FIFO, then rd_en for 1 cycle.
  - Required: data_out=0x1234 the cycle after the write, before any rd_en; after the pop, empty=1 and data_out=0.
- Flush and reset priority:
  - Stimulus: flush=1 at count=4 with wr_en=1; then rst=1 and flush=1 together.
  - Required: flush gives count=0, empty=1, wr_ack=0, overflow=0, data_out held. rst+flush gives the full reset values, including data_out=0.
